ibex_mult_pext_seq: RTL
=======================

# ibex_mult_pext_seq

Multi-cycle execution sequencer for the P-extension wide multiply ops (M32x32 and M32x16 classes), consuming the mode, cycle-count, crossed and accumulate controls produced by the P-ext multiplier decode. It time-shares one 33x17 signed multiplier, walks the decoded cycle count through a small FSM, and optionally performs the rd accumulate/subtract with signed saturation. It sits in the EX stage beside the ALU, with a valid/ready request port and a valid/ready result port.

## Interface
- No parameters.
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- kill_i  in  1  flush; aborts any in-flight op
- mult_mode_i  in  mult_pext_mode_e  decoded multiplier mode
- cycle_count_i  in  2  decoded cycles: 00=1, 01=2, 11=3
- accum_i  in  1  rd accumulate step required
- sub_i  in  1  accumulate subtracts (rd - prod)
- saturate_i  in  1  accumulate saturates to signed 32-bit
- crossed_i  in  1  M32x16: use B[31:16] instead of B[15:0]
- signed_a_i, signed_b_i  in  1 each  operand signedness
- high_i  in  1  M32x32: return product[63:32] (else [31:0])
- round_i  in  1  add rounding constant before taking the upper part
- op_a_i, op_b_i, op_c_i  in  32 each  rs1, rs2, rd
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumed
- result_o  out  32  result
- ov_o  out  1  saturation occurred (valid with res_valid_o)

## Operation
- States: IDLE, LO, HI, ACC, DONE. req_ready_o = (state==IDLE) && !rst_i. Accept latches all controls and operands.
- IDLE -> LO on accept. LO -> DONE if mode is M32x16; else -> HI. HI -> ACC if cycle_count==11 or accum_i; else -> DONE. ACC -> DONE. DONE -> IDLE when res_ready_i.
- cycle_count_i==10 is treated as 01. Modes M16x16/M8x8: LO -> DONE, result 0, ov 0.
- Multiplier: a_ext = {signed_a & A[31], A} (33b). LO (M32x32): b_ext = {0, B[15:0]}; HI: b_ext = {signed_b & B[31], B[31:16]}; M32x16: b_ext = sext of selected half (sign bit gated by signed_b). Product 50b signed.
- Accumulator acc (64b): LO: acc = sext64(prod). HI: acc = acc + (sext64(prod) << 16) + (round_i && high_i ? 2^31 : 0).
- M32x16 result: (prod + (round_i ? 2^15 : 0))[47:16].
- M32x32 mul result m = high_i ? acc[63:32] : acc[31:0].
- ACC: s = sext33(op_c) ± sext33(m). If saturate_i and s[32]!=s[31]: result = s[32] ? 0x80000000 : 0x7FFFFFFF, ov_o=1; else result = s[31:0], ov_o=0.
- result_o/ov_o registered, written on entry to DONE, held stable while res_valid_o && !res_ready_i.
- kill_i (any state but IDLE): next state IDLE, res_valid_o low next cycle; a killed DONE result is dropped. kill_i in IDLE blocks accept that cycle.
- rst_i wins over kill_i and all handshakes.

## Timing
- Reset: state IDLE, res_valid_o=0, result_o=0, ov_o=0, acc=0; req_ready_o=0 during reset cycles, 1 the cycle after.
- Accept at edge T: res_valid_o high from T+2 (M32x16), T+3 (M32x32, 2-cycle), T+4 (3-cycle/accumulate).
- res_valid_o is registered (state==DONE). Result valid and ready in the same cycle: the next accept is possible one cycle later (IDLE). No accept while DONE.
- No combinational path from req_valid_i to req_ready_o or from res_ready_i to res_valid_o.

## Structure
- Add mult_pext_seq_state_e (IDLE, LO, HI, ACC, DONE) to ibex_pkg_pext. mult_pext_mode_e is reused from there. Rounding constants are localparams.
- One sub-module: ibex_mult_pext_sat (33b add/sub + signed-32 saturation + ov flag), purely combinational.

## Test plan
- SMMUL: A=B=0x80000000, signed, high -> result 0x40000000, res_valid_o at T+3, ov_o=0.
- SMMULu rounding: A=0x00010000, B=0x00008000, high, round -> 0x00000001 (0 without round_i).
- MADDR32: A=3, B=5, C=10, low, 3 cycles -> 25 at T+4. With sub_i: 0xFFFFFFFB.
- KMMAC saturate: C=0x7FFFFFFF, A=B=0x7FFFFFFF, high, saturate -> 0x7FFFFFFF, ov_o=1.
- SMMWT crossed: A=0x00020000, B=0x00030000, M32x16, crossed -> 0x00000006 at T+2.
- Hold res_ready_i low 5 cycles: result_o stable, req_ready_o=0. Separately, kill_i during HI -> IDLE next cycle, no res_valid_o. Then a new request completes correctly.

Source files
------------

// File: rtl/ibex_pkg_pext.sv
// Shared types and constants for the P-extension multiplier decode and sequencer.
// Rounding constants are applied before the upper slice of a product is taken.
package ibex_pkg_pext;

  typedef enum logic [1:0] {
    MULT_PEXT_M16X16 = 2'd0,
    MULT_PEXT_M8X8   = 2'd1,
    MULT_PEXT_M32X16 = 2'd2,
    MULT_PEXT_M32X32 = 2'd3
  } mult_pext_mode_e;

  typedef enum logic [2:0] {
    MULT_SEQ_IDLE = 3'd0,
    MULT_SEQ_LO   = 3'd1,
    MULT_SEQ_HI   = 3'd2,
    MULT_SEQ_ACC  = 3'd3,
    MULT_SEQ_DONE = 3'd4
  } mult_pext_seq_state_e;

  localparam logic [63:0] RND_M32X32 = 64'h0000_0000_8000_0000;
  localparam logic [49:0] RND_M32X16 = 50'h0_0000_0000_8000;

  function automatic logic [63:0] sext64(input logic [49:0] v);
    return {{14{v[49]}}, v};
  endfunction

endpackage

// File: rtl/ibex_mult_pext_seq_if.sv
// Request/result bundle between the EX stage and the P-ext multiply sequencer.
// The master drives requests and consumes results; the slave is the sequencer.
interface ibex_mult_pext_seq_if;
  import ibex_pkg_pext::*;

  logic            req_valid_i;
  logic            req_ready_o;
  logic            kill_i;
  mult_pext_mode_e mult_mode_i;
  logic [1:0]      cycle_count_i;
  logic            accum_i;
  logic            sub_i;
  logic            saturate_i;
  logic            crossed_i;
  logic            signed_a_i;
  logic            signed_b_i;
  logic            high_i;
  logic            round_i;
  logic [31:0]     op_a_i;
  logic [31:0]     op_b_i;
  logic [31:0]     op_c_i;
  logic            res_valid_o;
  logic            res_ready_i;
  logic [31:0]     result_o;
  logic            ov_o;

  modport master (
    output req_valid_i, kill_i, mult_mode_i, cycle_count_i, accum_i, sub_i,
           saturate_i, crossed_i, signed_a_i, signed_b_i, high_i, round_i,
           op_a_i, op_b_i, op_c_i, res_ready_i,
    input  req_ready_o, res_valid_o, result_o, ov_o
  );

  modport slave (
    input  req_valid_i, kill_i, mult_mode_i, cycle_count_i, accum_i, sub_i,
           saturate_i, crossed_i, signed_a_i, signed_b_i, high_i, round_i,
           op_a_i, op_b_i, op_c_i, res_ready_i,
    output req_ready_o, res_valid_o, result_o, ov_o
  );

endinterface

// File: rtl/ibex_mult_pext_sat.sv
// rd accumulate/subtract on 33 bits with optional signed 32-bit saturation.
module ibex_mult_pext_sat (
  input  logic [31:0] op_c,
  input  logic [31:0] m,
  input  logic        sub,
  input  logic        saturate,
  output logic [31:0] result,
  output logic        ov
);

  logic [32:0] s;

  always_comb begin
    s      = sub ? ({op_c[31], op_c} - {m[31], m}) : ({op_c[31], op_c} + {m[31], m});
    result = s[31:0];
    ov     = 1'b0;
    // Bits 32 and 31 disagree only when the signed 32-bit range was exceeded.
    if (saturate && (s[32] != s[31])) begin
      ov     = 1'b1;
      result = s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

endmodule

// File: rtl/ibex_mult_pext_seq.sv
// Multi-cycle sequencer for P-ext M32x32/M32x16 multiplies on one shared 33x17
// signed multiplier, with optional rd accumulate and saturation.
module ibex_mult_pext_seq
  import ibex_pkg_pext::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  ibex_mult_pext_seq_if.slave  bus
);

  mult_pext_seq_state_e state_reg;
  mult_pext_mode_e      mode_reg;
  logic                 cyc3_reg;
  logic                 accum_reg;
  logic                 sub_reg;
  logic                 sat_reg;
  logic                 crossed_reg;
  logic                 signed_a_reg;
  logic                 signed_b_reg;
  logic                 high_reg;
  logic                 round_reg;
  logic [31:0]          a_reg;
  logic [31:0]          b_reg;
  logic [31:0]          c_reg;
  logic [63:0]          acc_reg;
  logic [31:0]          result_reg;
  logic                 ov_reg;

  logic signed [32:0]   a_ext;
  logic signed [16:0]   b_ext;
  logic [15:0]          b_half;
  logic signed [49:0]   prod;
  logic [49:0]          prod_rnd;
  logic [63:0]          acc_hi;
  logic [31:0]          m_hi;
  logic [31:0]          m_acc;
  logic [31:0]          sat_result;
  logic                 sat_ov;

  assign a_ext  = {signed_a_reg & a_reg[31], a_reg};
  assign b_half = crossed_reg ? b_reg[31:16] : b_reg[15:0];

  // The low half of B is always unsigned in the first M32x32 pass.
  always_comb begin
    b_ext = {1'b0, b_reg[15:0]};
    if (mode_reg == MULT_PEXT_M32X16) begin
      b_ext = {signed_b_reg & b_half[15], b_half};
    end else if (state_reg == MULT_SEQ_HI) begin
      b_ext = {signed_b_reg & b_reg[31], b_reg[31:16]};
    end
  end

  assign prod     = a_ext * b_ext;
  assign prod_rnd = prod + (round_reg ? RND_M32X16 : 50'd0);
  assign acc_hi   = acc_reg + (sext64(prod) << 16)
                  + ((round_reg && high_reg) ? RND_M32X32 : 64'd0);
  assign m_hi     = high_reg ? acc_hi[63:32] : acc_hi[31:0];
  assign m_acc    = high_reg ? acc_reg[63:32] : acc_reg[31:0];

  ibex_mult_pext_sat u_sat (
    .op_c     (c_reg),
    .m        (m_acc),
    .sub      (sub_reg),
    .saturate (sat_reg),
    .result   (sat_result),
    .ov       (sat_ov)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= MULT_SEQ_IDLE;
      acc_reg    <= 64'd0;
      result_reg <= 32'd0;
      ov_reg     <= 1'b0;
    end else if (bus.kill_i && (state_reg != MULT_SEQ_IDLE)) begin
      state_reg <= MULT_SEQ_IDLE;
    end else begin
      case (state_reg)
        MULT_SEQ_IDLE: begin
          if (bus.req_valid_i && !bus.kill_i) begin
            mode_reg     <= bus.mult_mode_i;
            cyc3_reg     <= (bus.cycle_count_i == 2'b11);
            accum_reg    <= bus.accum_i;
            sub_reg      <= bus.sub_i;
            sat_reg      <= bus.saturate_i;
            crossed_reg  <= bus.crossed_i;
            signed_a_reg <= bus.signed_a_i;
            signed_b_reg <= bus.signed_b_i;
            high_reg     <= bus.high_i;
            round_reg    <= bus.round_i;
            a_reg        <= bus.op_a_i;
            b_reg        <= bus.op_b_i;
            c_reg        <= bus.op_c_i;
            state_reg    <= MULT_SEQ_LO;
          end
        end
        MULT_SEQ_LO: begin
          case (mode_reg)
            MULT_PEXT_M32X32: begin
              acc_reg   <= sext64(prod);
              state_reg <= MULT_SEQ_HI;
            end
            MULT_PEXT_M32X16: begin
              result_reg <= prod_rnd[47:16];
              ov_reg     <= 1'b0;
              state_reg  <= MULT_SEQ_DONE;
            end
            default: begin
              result_reg <= 32'd0;
              ov_reg     <= 1'b0;
              state_reg  <= MULT_SEQ_DONE;
            end
          endcase
        end
        MULT_SEQ_HI: begin
          if (cyc3_reg || accum_reg) begin
            acc_reg   <= acc_hi;
            state_reg <= MULT_SEQ_ACC;
          end else begin
            result_reg <= m_hi;
            ov_reg     <= 1'b0;
            state_reg  <= MULT_SEQ_DONE;
          end
        end
        MULT_SEQ_ACC: begin
          result_reg <= sat_result;
          ov_reg     <= sat_ov;
          state_reg  <= MULT_SEQ_DONE;
        end
        MULT_SEQ_DONE: begin
          if (bus.res_ready_i) state_reg <= MULT_SEQ_IDLE;
        end
        default: state_reg <= MULT_SEQ_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = (state_reg == MULT_SEQ_IDLE) && !rst_i;
  assign bus.res_valid_o = (state_reg == MULT_SEQ_DONE);
  assign bus.result_o    = result_reg;
  assign bus.ov_o        = ov_reg;

endmodule
